// File: rtl/sprite_layer_mux.sv
// Fixed-priority sprite layer selector with a registered pixel output and
// per-frame layer overlap (collision) accumulation published at frame start.
module sprite_layer_mux #(
  parameter int ELEMENT  = 5,
  parameter int ADDR_W   = 10,
  parameter int N_LAYERS = 4,
  localparam int WIN_W   = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic                         frame_start,
  input  logic [N_LAYERS-1:0]          layer_en,
  input  logic [N_LAYERS-1:0]          layer_mask,
  input  logic [N_LAYERS*ELEMENT-1:0]  layer_element,
  input  logic [N_LAYERS*ADDR_W-1:0]   layer_address,
  output logic                         ready,
  output logic [ELEMENT-1:0]           element,
  output logic [ADDR_W-1:0]            address,
  output logic [WIN_W-1:0]             winner,
  output logic [N_LAYERS-1:0]          collision_status,
  output logic                         collision_irq
);

  // Handshake: ready is a pure valid flag for element/address of the current
  // pixel. There is no back-pressure; the consumer takes one pixel per cycle.

  logic [N_LAYERS-1:0] vis;
  logic [N_LAYERS-1:0] overlap_bits;
  logic [N_LAYERS-1:0] published;
  logic                multi_vis;
  logic                any_vis;
  logic [WIN_W-1:0]    win_idx;
  logic [ELEMENT-1:0]  win_element;
  logic [ADDR_W-1:0]   win_address;

  logic                ready_q, ready_d;
  logic [ELEMENT-1:0]  element_q, element_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [WIN_W-1:0]    winner_q, winner_d;
  logic [N_LAYERS-1:0] status_q, status_d;
  logic                irq_q, irq_d;
  logic [N_LAYERS-1:0] acc_q, acc_d;

  assign vis       = layer_en & ~layer_mask & {N_LAYERS{active}};
  assign any_vis   = |vis;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_vis = |(vis & (vis - {{(N_LAYERS-1){1'b0}}, 1'b1}));
  assign overlap_bits = multi_vis ? vis : '0;
  assign published    = acc_q | overlap_bits;

  always_comb begin
    win_idx     = '0;
    win_element = '0;
    win_address = '0;
    // Scan from the top so the lowest visible index is the last to assign.
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (vis[i]) begin
        win_idx     = i[WIN_W-1:0];
        win_element = layer_element[i*ELEMENT +: ELEMENT];
        win_address = layer_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    ready_d   = any_vis;
    element_d = element_q;
    address_d = address_q;
    winner_d  = winner_q;
    status_d  = status_q;
    irq_d     = 1'b0;
    acc_d     = acc_q | overlap_bits;
    if (any_vis) begin
      element_d = win_element;
      address_d = win_address;
      winner_d  = win_idx;
    end
    if (frame_start) begin
      status_d = published;
      irq_d    = |published;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      element_q <= '0;
      address_q <= '0;
      winner_q  <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      element_q <= element_d;
      address_q <= address_d;
      winner_q  <= winner_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      acc_q     <= acc_d;
    end
  end

  assign ready            = ready_q;
  assign element          = element_q;
  assign address          = address_q;
  assign winner           = winner_q;
  assign collision_status = status_q;
  assign collision_irq    = irq_q;

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Bench for sprite_layer_mux: directed scenarios followed by random traffic,
// all checked against a frame-level behavioural model.
module tb_sprite_layer_mux;

  localparam int N  = 4;
  localparam int EW = 5;
  localparam int AW = 10;
  localparam int WW = 2;

  logic            clk;
  logic            reset;
  logic            active;
  logic            frame_start;
  logic [N-1:0]    layer_en;
  logic [N-1:0]    layer_mask;
  logic [N*EW-1:0] layer_element;
  logic [N*AW-1:0] layer_address;
  logic            ready;
  logic [EW-1:0]   element;
  logic [AW-1:0]   address;
  logic [WW-1:0]   winner;
  logic [N-1:0]    collision_status;
  logic            collision_irq;

  sprite_layer_mux #(.ELEMENT(EW), .ADDR_W(AW), .N_LAYERS(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .active           (active),
    .frame_start      (frame_start),
    .layer_en         (layer_en),
    .layer_mask       (layer_mask),
    .layer_element    (layer_element),
    .layer_address    (layer_address),
    .ready            (ready),
    .element          (element),
    .address          (address),
    .winner           (winner),
    .collision_status (collision_status),
    .collision_irq    (collision_irq)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: what the outputs should show after the most recent edge.
  int m_ready, m_element, m_address, m_winner, m_status, m_irq;
  int frame_hits[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel, described in terms of the rules rather than register logic.
  task automatic model_pixel();
    int shown[$];
    int pub;
    if (reset) begin
      m_ready = 0; m_element = 0; m_address = 0; m_winner = 0;
      m_status = 0; m_irq = 0;
      foreach (frame_hits[i]) frame_hits[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (active && layer_en[i] && !layer_mask[i]) shown.push_back(i);
    if (shown.size() > 0) begin
      m_ready   = 1;
      m_winner  = shown[0];
      m_element = int'(layer_element[shown[0]*EW +: EW]);
      m_address = int'(layer_address[shown[0]*AW +: AW]);
    end else begin
      m_ready = 0;
    end
    if (shown.size() >= 2)
      foreach (shown[k]) frame_hits[shown[k]] = 1;
    if (frame_start) begin
      pub = 0;
      for (int i = 0; i < N; i++) if (frame_hits[i] != 0) pub += (1 << i);
      m_status = pub;
      m_irq    = (pub != 0) ? 1 : 0;
      foreach (frame_hits[i]) frame_hits[i] = 0;
    end else begin
      m_irq = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_pixel();
    check("ready",   32'(ready),            32'(m_ready));
    check("element", 32'(element),          32'(m_element));
    check("address", 32'(address),          32'(m_address));
    check("winner",  32'(winner),           32'(m_winner));
    check("status",  32'(collision_status), 32'(m_status));
    check("irq",     32'(collision_irq),    32'(m_irq));
  endtask

  task automatic set_layer(input int i, input logic [EW-1:0] el, input logic [AW-1:0] ad);
    layer_element[i*EW +: EW] = el;
    layer_address[i*AW +: AW] = ad;
  endtask

  initial begin
    reset = 1'b1; active = 1'b1; frame_start = 1'b0;
    layer_en = '0; layer_mask = '0; layer_element = '0; layer_address = '0;
    foreach (frame_hits[i]) frame_hits[i] = 0;
    m_ready = 0; m_element = 0; m_address = 0; m_winner = 0; m_status = 0; m_irq = 0;
    step(); step();
    check("rst_ready",  32'(ready), 32'd0);
    check("rst_status", 32'(collision_status), 32'd0);
    reset = 1'b0;

    // Idle frame
    for (int c = 0; c < 10; c++) step();
    check("idle_element", 32'(element), 32'd0);
    check("idle_address", 32'(address), 32'd0);

    // Two visible layers: lower index wins, both flagged
    frame_start = 1'b1; step(); frame_start = 1'b0;
    set_layer(1, 5'd1, 10'h012); set_layer(2, 5'd3, 10'h200);
    layer_en = 4'b0110; step();
    check("pri_element", 32'(element), 32'd1);
    check("pri_address", 32'(address), 32'h012);
    check("pri_winner",  32'(winner),  32'd1);
    layer_en = 4'b0000; frame_start = 1'b1; step(); frame_start = 1'b0;
    check("pri_status", 32'(collision_status), 32'b0110);
    check("pri_irq",    32'(collision_irq), 32'd1);
    step();
    check("pri_irq_drop", 32'(collision_irq), 32'd0);

    // Masking layer 1 hides it from display and collision
    layer_en = 4'b0110; layer_mask = 4'b0010; step();
    check("mask_element", 32'(element), 32'd3);
    check("mask_address", 32'(address), 32'h200);
    check("mask_winner",  32'(winner),  32'd2);
    layer_en = 4'b0000; layer_mask = 4'b0000; frame_start = 1'b1; step(); frame_start = 1'b0;
    check("mask_status", 32'(collision_status), 32'b0000);
    check("mask_irq",    32'(collision_irq), 32'd0);

    // Layers 0 and 3 overlap mid-frame
    set_layer(0, 5'd7, 10'h055); set_layer(3, 5'd9, 10'h0AA);
    layer_en = 4'b1001; step();
    layer_en = 4'b0000; step(); step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("ovl_status", 32'(collision_status), 32'b1001);
    check("ovl_irq",    32'(collision_irq), 32'd1);
    step(); step();
    check("ovl_hold", 32'(collision_status), 32'b1001);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("clean_status", 32'(collision_status), 32'b0000);
    check("clean_irq",    32'(collision_irq), 32'd0);

    // Hold on no-visible, and active=0 suppression
    set_layer(0, 5'd5, 10'h3FF);
    layer_en = 4'b0001; step();
    layer_en = 4'b0000; step();
    check("hold_ready",   32'(ready),   32'd0);
    check("hold_element", 32'(element), 32'd5);
    check("hold_address", 32'(address), 32'h3FF);
    active = 1'b0; layer_en = 4'b1111; step(); step();
    check("blank_ready", 32'(ready), 32'd0);
    active = 1'b1; layer_en = 4'b0000; frame_start = 1'b1; step(); frame_start = 1'b0;
    check("blank_status", 32'(collision_status), 32'b0000);

    // Overlap in the frame_start cycle itself
    layer_en = 4'b1100; frame_start = 1'b1; step(); frame_start = 1'b0;
    check("fs_ovl_status", 32'(collision_status), 32'b1100);
    check("fs_ovl_irq",    32'(collision_irq), 32'd1);
    layer_en = 4'b0000; step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("fs_ovl_cleared", 32'(collision_status), 32'b0000);

    // Back-to-back frame_start pulses
    layer_en = 4'b0011; step();
    layer_en = 4'b0000; frame_start = 1'b1; step();
    layer_en = 4'b0101; step(); frame_start = 1'b0; layer_en = 4'b0000;
    check("b2b_status", 32'(collision_status), 32'b0101);
    step();

    // Reset mid-frame discards accumulated overlaps
    layer_en = 4'b0011; step();
    layer_en = 4'b0000; reset = 1'b1; step(); reset = 1'b0; step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("rst_mid_status", 32'(collision_status), 32'b0000);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      active        = ($urandom_range(0, 7) != 0);
      frame_start   = ($urandom_range(0, 15) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      layer_en      = N'($urandom);
      layer_mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      layer_element = (N*EW)'($urandom);
      layer_address = (N*AW)'({$urandom, $urandom});
      step();
    end
    reset = 1'b0; frame_start = 1'b0; layer_en = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sprite_layer_mux.md
Name: sprite_layer_mux

Overview:
- Parametrised successor to the two-source sprite selector in the VGA pixel path.
- Takes N_LAYERS sprite generators (barrier, fruit, snake head/body, ...). Each generator supplies an enable, a sprite-memory address and an element ID.
- Each cycle, the block picks the highest-priority visible layer and presents a registered element/address/ready to the sprite memory stage.
- It also accumulates per-layer overlap (collision) flags over a frame and publishes them at frame start for the game-logic FSM.

Parameters:
- ELEMENT, 5: width of element ID per layer and on the output.
- ADDR_W, 10: sprite-memory address width per layer and on the output.
- N_LAYERS, 4: number of input sprite layers; minimum 2.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- active  in  1  VGA visible-region flag; when low, no layer may win and no collision may be recorded.
- frame_start  in  1  single-cycle pulse at the first cycle of each frame.
- layer_en  in  N_LAYERS  per-layer enable (pixel inside that sprite); bit i = layer i.
- layer_mask  in  N_LAYERS  per-layer hide; 1 = layer ignored for both display and collision.
- layer_element  in  N_LAYERS*ELEMENT  element IDs; layer i occupies bits [i*ELEMENT +: ELEMENT].
- layer_address  in  N_LAYERS*ADDR_W  addresses; layer i occupies bits [i*ADDR_W +: ADDR_W].
- ready  out  1  registered; output element/address valid for this pixel.
- element  out  ELEMENT  registered element ID of the winning layer.
- address  out  ADDR_W  registered address of the winning layer.
- winner  out  clog2(N_LAYERS)  registered index of the winning layer.
- collision_status  out  N_LAYERS  collision flags of the previous frame.
- collision_irq  out  1  one-cycle pulse when a published collision_status is nonzero.

Behaviour:
- Reset values: ready=0, element=0, address=0, winner=0, collision_status=0, collision_irq=0, internal collision accumulator=0.
- Visibility: vis[i] = layer_en[i] & ~layer_mask[i] & active.
- Priority is fixed: the lowest index wins (layer 0 highest). Layer 0 is the barrier slot by convention.
- Latency is exactly 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- If any vis bit is set: ready<=1, and element/address/winner take the values of the winning layer.
- If no vis bit is set: ready<=0, and element/address/winner HOLD their previous values (they are not cleared).
- Overlap: when popcount(vis) >= 2, every layer with vis[i]=1 sets bit i in the accumulator. Bits are sticky within the frame.
- On frame_start=1:
  - collision_status <= accumulator OR the overlap bits of the same cycle, so no pixel is lost.
  - The accumulator is cleared to 0 for the new frame.
  - collision_irq <= 1 if that published value is nonzero, else 0.
- collision_irq is high for exactly one cycle. It is 0 in every cycle without frame_start.
- collision_status holds its value between frame_start pulses.
- Back-to-back frame_start pulses are legal. Each pulse publishes and clears; the second pulse publishes only overlaps from its own cycle.
- Reset has priority over all inputs. A reset mid-frame discards the accumulator, and the next frame_start publishes only post-reset overlaps.
- Masked layers never win and never set collision bits, even when layer_en=1.
- With active=0, pixels are neither displayed nor counted, regardless of layer_en.
- Pure datapath plus the accumulator. No back-pressure: the downstream stage must accept one pixel per cycle.

Test Plan:
- Reset, then idle with all layer_en=0 for 10 cycles -> ready=0, element=0, address=0, collision_status=0, collision_irq never high.
- N_LAYERS=4, active=1, layer_en=4'b0110, layer1 {element 1, address 0x012}, layer2 {element 3, address 0x200} -> one cycle later ready=1, element=1, address=0x012, winner=1; accumulator bits 1 and 2 set.
- Same stimulus with layer_mask=4'b0010 -> element=3, address=0x200, winner=2, and no collision recorded. Next frame_start -> collision_status=4'b0000, collision_irq=0.
- Overlap of layers 0 and 3 mid-frame, then frame_start -> collision_status=4'b1001 and collision_irq=1 for one cycle. The following frame has no overlap; at its frame_start -> status=0, irq=0.
- layer_en=4'b0001 with element 5, address 0x3FF, then layer_en=0 -> ready falls to 0 while element stays 5 and address stays 0x3FF. With active=0 and layer_en=4'b1111 -> ready=0 and no collision.
- Overlap on layers 2 and 3 in the same cycle as frame_start -> collision_status=4'b1100 and irq=1; the accumulator after the pulse is 0. Separately, reset asserted mid-frame after an overlap, then frame_start -> status=0.
